// File: rtl/pio_bank_pkg.sv
// Shared types, register-map offsets and byte-enable helper for the PIO bank.
package pio_bank_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } prime_state_e;

    // Widest byte-enable the expand helper handles (256-bit data words).
    localparam int MAX_BE_W = 32;

    function automatic int out_base();
        return 0;
    endfunction

    function automatic int in_base(input int n_out);
        return n_out;
    endfunction

    function automatic int edge_base(input int n_out, input int n_in);
        return n_out + n_in;
    endfunction

    function automatic int mask_base(input int n_out, input int n_in);
        return n_out + 2 * n_in;
    endfunction

    function automatic logic [8*MAX_BE_W-1:0] expand_be(input logic [MAX_BE_W-1:0] be);
        logic [8*MAX_BE_W-1:0] m;
        for (int i = 0; i < MAX_BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pio_in_channel.sv
// One input word: synchroniser, edge detector, W1C capture register and irq mask.
module pio_in_channel
    import pio_bank_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_async,
    input  logic              edge_en,
    input  logic [DATA_W-1:0] cap_clr,
    input  logic [DATA_W-1:0] mask_we,
    input  logic [DATA_W-1:0] mask_wdata,
    output logic [DATA_W-1:0] sync_val,
    output logic [DATA_W-1:0] capture,
    output logic [DATA_W-1:0] mask,
    output logic              irq_term
);

    localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);

    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] dly_q;
    logic [DATA_W-1:0] rise;
    logic [DATA_W-1:0] fall;
    logic [DATA_W-1:0] det;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            dly_q <= '0;
        end else begin
            sync_q[0] <= in_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign rise     = ~dly_q & sync_val;
    assign fall     = dly_q & ~sync_val;

    always_comb begin
        det = '0;
        if (edge_en) begin
            case (MODE)
                EDGE_RISE: det = rise;
                EDGE_FALL: det = fall;
                default:   det = rise | fall;
            endcase
        end
    end

    // A newly detected edge overrides a same-cycle clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
            mask    <= '0;
        end else begin
            capture <= (capture & ~cap_clr) | det;
            mask    <= (mask & ~mask_we) | (mask_wdata & mask_we);
        end
    end

    assign irq_term = |(capture & mask);

endmodule

// File: rtl/avmm_pio_bank.sv
// Avalon-MM PIO bank: R/W output words plus synchronised, edge-captured input words with irq.
//  state | meaning
//  PRIME | counting down after reset release; edge capture suppressed
//  RUN   | normal operation; edges captured
module avmm_pio_bank
    import pio_bank_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int N_OUT       = 4,
    parameter int N_IN        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int ADDR_W      = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [DATA_W/8-1:0]     avs_byteenable,
    input  logic [DATA_W-1:0]       avs_writedata,
    output logic [DATA_W-1:0]       avs_readdata,
    output logic                    irq,
    output logic [N_OUT*DATA_W-1:0] out_export,
    input  logic [N_IN*DATA_W-1:0]  in_export
);

    localparam int OUT_BASE  = out_base();
    localparam int IN_BASE   = in_base(N_OUT);
    localparam int EDGE_BASE = edge_base(N_OUT, N_IN);
    localparam int MASK_BASE = mask_base(N_OUT, N_IN);
    localparam int CNT_W     = $clog2(SYNC_STAGES + 1);

    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] out_q    [N_OUT];
    logic [DATA_W-1:0] sync_val [N_IN];
    logic [DATA_W-1:0] capture  [N_IN];
    logic [DATA_W-1:0] mask     [N_IN];
    logic [N_IN-1:0]   irq_term;
    logic [DATA_W-1:0] rd_mux;
    logic              edge_en;

    prime_state_e      state_q;
    prime_state_e      state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    assign bit_mask = DATA_W'(expand_be(MAX_BE_W'(avs_byteenable)));

    // Edges are held off for SYNC_STAGES+1 cycles so a level already high at
    // reset release, rippling through the zeroed synchroniser, is not captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PRIME;
            cnt_q   <= CNT_W'(SYNC_STAGES);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PRIME: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    assign edge_en = (state_q == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= '0;
            end
        end else if (avs_write) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (avs_address == ADDR_W'(OUT_BASE + k)) begin
                    out_q[k] <= (out_q[k] & ~bit_mask) | (avs_writedata & bit_mask);
                end
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_export[k*DATA_W +: DATA_W] = out_q[k];
    end

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        logic edge_sel;
        logic mask_sel;

        assign edge_sel = avs_write && (avs_address == ADDR_W'(EDGE_BASE + k));
        assign mask_sel = avs_write && (avs_address == ADDR_W'(MASK_BASE + k));

        pio_in_channel #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .in_async   (in_export[k*DATA_W +: DATA_W]),
            .edge_en    (edge_en),
            .cap_clr    ({DATA_W{edge_sel}} & avs_writedata & bit_mask),
            .mask_we    ({DATA_W{mask_sel}} & bit_mask),
            .mask_wdata (avs_writedata),
            .sync_val   (sync_val[k]),
            .capture    (capture[k]),
            .mask       (mask[k]),
            .irq_term   (irq_term[k])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (avs_address == ADDR_W'(OUT_BASE + k)) rd_mux = out_q[k];
        end
        for (int k = 0; k < N_IN; k++) begin
            if (avs_address == ADDR_W'(IN_BASE + k))   rd_mux = sync_val[k];
            if (avs_address == ADDR_W'(EDGE_BASE + k)) rd_mux = capture[k];
            if (avs_address == ADDR_W'(MASK_BASE + k)) rd_mux = mask[k];
        end
    end

    // Mux sees pre-write register state, so a simultaneous write is not visible in the read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (avs_read) avs_readdata <= rd_mux;
            irq <= |irq_term;
        end
    end

endmodule

// File: tb/tb_avmm_pio_bank.sv
// Bench for avmm_pio_bank: vector table, directed corner sequences and a random phase
// checked against an event-history reference model. Two instances cover rising and both-edge modes.
module tb_avmm_pio_bank;

    localparam int S = 2;

    logic         clk;
    logic         reset_n;
    logic [3:0]   avs_address;
    logic         avs_read;
    logic         avs_write;
    logic [3:0]   avs_byteenable;
    logic [31:0]  avs_writedata;
    logic [63:0]  in_export;
    logic [31:0]  rdata_a, rdata_b;
    logic         irq_a, irq_b;
    logic [127:0] out_a, out_b;

    int n_chk = 0;
    int n_err = 0;

    avmm_pio_bank #(.EDGE_MODE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
        .avs_readdata(rdata_a), .irq(irq_a), .out_export(out_a), .in_export(in_export));

    avmm_pio_bank #(.EDGE_MODE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
        .avs_readdata(rdata_b), .irq(irq_b), .out_export(out_b), .in_export(in_export));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: index 0 = rising-only instance, 1 = both-edge instance.
    logic [31:0] m_out [4];
    logic [31:0] m_mask [2];
    logic [31:0] m_cap [2][2];
    logic [31:0] m_rd [2];
    logic        m_irq [2];
    logic [63:0] hist [$];
    int          n_edge;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] hist_at(input int i);
        if (i <= 0) return 64'h0;
        return hist[i-1];
    endfunction

    function automatic logic [31:0] m_read(input int m, input int a, input logic [63:0] sw);
        if (a < 4)  return m_out[a];
        if (a < 6)  return sw[(a-4)*32 +: 32];
        if (a < 8)  return m_cap[m][a-6];
        if (a < 10) return m_mask[a-8];
        return 32'h0;
    endfunction

    function automatic logic [127:0] m_out_packed();
        return {m_out[3], m_out[2], m_out[1], m_out[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        for (int m = 0; m < 2; m++) begin
            m_rd[m]  = '0;
            m_irq[m] = 1'b0;
            m_mask[m] = '0;
            for (int k = 0; k < 2; k++) m_cap[m][k] = '0;
        end
        hist.delete();
        n_edge = 0;
    endtask

    // Edge n captures the change between the input seen at edges n-S-1 and n-S,
    // once n is past the SYNC_STAGES+1 priming window.
    task automatic model_edge(input logic rd, input logic wr, input logic [3:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
        logic [63:0] sw, cur, prev;
        logic [31:0] bm, det, clr;
        logic        irq_n;
        int          a;
        a  = int'(addr);
        sw = hist_at(n_edge - S + 1);
        for (int m = 0; m < 2; m++) begin
            irq_n = 1'b0;
            for (int k = 0; k < 2; k++) irq_n = irq_n | (|(m_cap[m][k] & m_mask[k]));
            m_irq[m] = irq_n;
            if (rd) m_rd[m] = m_read(m, a, sw);
        end
        hist.push_back(in_export);
        n_edge++;
        cur  = hist_at(n_edge - S);
        prev = hist_at(n_edge - S - 1);
        for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{be[i]}};
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 2; k++) begin
                det = '0;
                if (n_edge >= S + 2) begin
                    det = ~prev[k*32 +: 32] & cur[k*32 +: 32];
                    if (m == 1) det = det | (prev[k*32 +: 32] & ~cur[k*32 +: 32]);
                end
                clr = (wr && a == 6 + k) ? (wd & bm) : 32'h0;
                m_cap[m][k] = (m_cap[m][k] & ~clr) | det;
            end
        end
        if (wr && a < 4) m_out[a] = (m_out[a] & ~bm) | (wd & bm);
        if (wr && (a == 8 || a == 9)) m_mask[a-8] = (m_mask[a-8] & ~bm) | (wd & bm);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rd_a"}, 128'(rdata_a), 128'(m_rd[0]));
        chk({tag, "_rd_b"}, 128'(rdata_b), 128'(m_rd[1]));
        chk({tag, "_irq_a"}, 128'(irq_a), 128'(m_irq[0]));
        chk({tag, "_irq_b"}, 128'(irq_b), 128'(m_irq[1]));
        chk({tag, "_out"}, out_a | out_b, m_out_packed());
    endtask

    // Called at a negedge; drives one bus cycle, advances the model, checks at the next negedge.
    task automatic cycle(input logic rd, input logic wr, input logic [3:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        avs_read = rd; avs_write = wr; avs_address = addr;
        avs_byteenable = be; avs_writedata = wd;
        @(posedge clk);
        model_edge(rd, wr, addr, be, wd);
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        check_model("mdl");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [26];

    initial begin
        for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 1'b0, 4'(i), 4'h0, 32'h0, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 4'd1,  4'hF, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 4'd1,  4'h5, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 4'd1,  4'h0, 32'h0,        1'b1, 32'h00AD00EF};
        vecs[13] = '{1'b0, 1'b1, 4'd15, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 4'd15, 4'h0, 32'h0,        1'b1, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 4'd0,  4'hF, 32'h11111111, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b1, 4'd0,  4'hF, 32'h22222222, 1'b1, 32'h11111111};
        vecs[17] = '{1'b1, 1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 32'h22222222};
        vecs[18] = '{1'b0, 1'b1, 4'd4,  4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[19] = '{1'b1, 1'b0, 4'd4,  4'h0, 32'h0,        1'b1, 32'h0};
        vecs[20] = '{1'b0, 1'b1, 4'd8,  4'h3, 32'h12345678, 1'b0, 32'h0};
        vecs[21] = '{1'b1, 1'b0, 4'd8,  4'h0, 32'h0,        1'b1, 32'h00005678};
        vecs[22] = '{1'b1, 1'b0, 4'd10, 4'h0, 32'h0,        1'b1, 32'h0};
        vecs[23] = '{1'b1, 1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 32'h22222222};
        vecs[24] = '{1'b0, 1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 32'h22222222};
        vecs[25] = '{1'b0, 1'b1, 4'd8,  4'hF, 32'h0,        1'b0, 32'h0};

        avs_read = 0; avs_write = 0; avs_address = 0; avs_byteenable = 0; avs_writedata = 0;
        in_export = '0;
        reset_n = 1'b0;
        @(negedge clk);
        do_reset();
        chk("reset_irq_a", 128'(irq_a), 128'(0));
        chk("reset_out_a", out_a, 128'(0));

        // Register map, byte enables, unmapped and read-during-write.
        for (int i = 0; i < 26; i++) begin
            cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd);
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d_a", i), 128'(rdata_a), 128'(vecs[i].exp));
                chk($sformatf("vec%0d_b", i), 128'(rdata_b), 128'(vecs[i].exp));
            end
        end
        chk("out_after_table", out_a, {32'h0, 32'h0, 32'h00AD00EF, 32'h22222222});

        // Input high through reset release must not be captured; then bit 3 edge latency.
        in_export = 64'h1;
        do_reset();
        idle(S + 3);
        cycle(1'b1, 1'b0, 4'd6, 4'h0, 32'h0);
        chk("prime_a", 128'(rdata_a), 128'(0));
        chk("prime_b", 128'(rdata_b), 128'(0));
        in_export = 64'h9;
        for (int j = 1; j <= 4; j++) begin
            cycle(1'b1, 1'b0, 4'd6, 4'h0, 32'h0);
            chk($sformatf("lat%0d_a", j), 128'(rdata_a), 128'((j < 4) ? 32'h0 : 32'h8));
            chk($sformatf("lat%0d_b", j), 128'(rdata_b), 128'((j < 4) ? 32'h0 : 32'h8));
        end

        // Mask -> irq, W1C -> irq drops, W1C colliding with a new edge.
        cycle(1'b0, 1'b1, 4'd8, 4'hF, 32'h8);
        chk("irq_mask_wr_a", 128'(irq_a), 128'(0));
        idle(1);
        chk("irq_on_a", 128'(irq_a), 128'(1));
        chk("irq_on_b", 128'(irq_b), 128'(1));
        cycle(1'b0, 1'b1, 4'd6, 4'hF, 32'h8);
        chk("irq_w1c_wr_a", 128'(irq_a), 128'(1));
        idle(1);
        chk("irq_off_a", 128'(irq_a), 128'(0));
        chk("irq_off_b", 128'(irq_b), 128'(0));
        in_export = 64'h1; idle(4);
        in_export = 64'h9; idle(4);
        in_export = 64'h1; idle(4);
        in_export = 64'h9; idle(2);
        cycle(1'b0, 1'b1, 4'd6, 4'hF, 32'h8);
        cycle(1'b1, 1'b0, 4'd6, 4'h0, 32'h0);
        chk("setwins_a", 128'(rdata_a), 128'(32'h8));
        chk("setwins_b", 128'(rdata_b), 128'(32'h8));
        chk("setwins_irq_a", 128'(irq_a), 128'(1));
        chk("setwins_irq_b", 128'(irq_b), 128'(1));

        // Asynchronous reset mid-operation.
        cycle(1'b0, 1'b1, 4'd2, 4'hF, 32'hA5A5A5A5);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_a", out_a, 128'(0));
        chk("rst_rd_a", 128'(rdata_a), 128'(0));
        chk("rst_irq_a", 128'(irq_a), 128'(0));
        chk("rst_irq_b", 128'(irq_b), 128'(0));
        in_export = '0;
        @(negedge clk);
        reset_n = 1'b1;

        // Both-edge mode: a 4-cycle pulse gives a capture on each edge.
        idle(S + 2);
        in_export = 64'h1;
        idle(2);
        cycle(1'b1, 1'b0, 4'd4, 4'h0, 32'h0);
        chk("pulse_in_b", 128'(rdata_b), 128'(1));
        cycle(1'b1, 1'b1, 4'd6, 4'hF, 32'h1);
        chk("pulse_rise_a", 128'(rdata_a), 128'(1));
        chk("pulse_rise_b", 128'(rdata_b), 128'(1));
        in_export = 64'h0;
        idle(5);
        cycle(1'b1, 1'b0, 4'd6, 4'h0, 32'h0);
        chk("pulse_fall_a", 128'(rdata_a), 128'(0));
        chk("pulse_fall_b", 128'(rdata_b), 128'(1));
        cycle(1'b0, 1'b1, 4'd6, 4'hF, 32'h1);
        cycle(1'b1, 1'b0, 4'd6, 4'h0, 32'h0);
        chk("pulse_clr_b", 128'(rdata_b), 128'(0));

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            if ($urandom_range(0, 3) == 0) in_export = {$urandom, $urandom};
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
